// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit ends of the Segway link.
// Holds link rates, counter widths, command bytes and the receiver state encoding.
package uart_pkg;

    localparam int unsigned CLK_FREQ      = 50_000_000;
    localparam int unsigned BAUD          = 19200;
    localparam int unsigned BAUD_DIV_DFLT = 2604;

    localparam int unsigned CNT_W     = 12;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned BIT_CNT_W = 3;

    localparam logic [DATA_W-1:0] CMD_GO   = 8'h67;
    localparam logic [DATA_W-1:0] CMD_STOP = 8'h73;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Counter reload value for a span of n clocks (counter strobes on reaching zero).
    function automatic logic [CNT_W-1:0] cnt_load(input int unsigned n);
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   d          : asynchronous input
//   q          : synchronized output, reset to RST_VAL
module rx_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Reset to the input's idle level so no false edge appears after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Samples each bit at its centre using a down-counting baud
// timer, flags framing errors and overruns, and hands each good byte to the
// consumer with a rdy/clr_rdy handshake.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   RX         : serial line, idle high, asynchronous to clk
//   clr_rdy    : consumer pulse, clears rdy, frm_err and ovr_err
//   rx_data    : last good byte received (LSB first on the wire)
//   rdy        : good byte available, held until clr_rdy
//   frm_err    : sticky, last frame had a low stop bit
//   ovr_err    : sticky, a good frame completed while rdy was still high
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = BAUD_DIV_DFLT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RX,
    input  logic              clr_rdy,
    output logic [DATA_W-1:0] rx_data,
    output logic              rdy,
    output logic              frm_err,
    output logic              ovr_err
);

    localparam logic [CNT_W-1:0] FULL_LOAD = cnt_load(BAUD_DIV);
    localparam logic [CNT_W-1:0] HALF_LOAD = cnt_load(BAUD_DIV / 2);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);

    rx_state_t            state;
    logic                 rx_s;
    logic [CNT_W-1:0]     baud_cnt;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [DATA_W-1:0]    shift;
    logic                 strobe_c;

    // Line synchronizer; resets to the idle (high) level.
    rx_sync #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (RX),
        .q     (rx_s)
    );

    assign strobe_c = (baud_cnt == '0);

    // Receive FSM, baud timer, bit counter, shifter and output flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            rx_data  <= '0;
            rdy      <= 1'b0;
            frm_err  <= 1'b0;
            ovr_err  <= 1'b0;
        end else begin
            // Consumer clear; frame completion below overrides it in the same cycle.
            if (clr_rdy) begin
                rdy     <= 1'b0;
                frm_err <= 1'b0;
                ovr_err <= 1'b0;
            end

            // Timer runs in every state except IDLE, reloading a full bit at each strobe.
            if (state != IDLE) begin
                baud_cnt <= strobe_c ? FULL_LOAD : baud_cnt - CNT_W'(1);
            end

            unique case (state)
                IDLE: begin
                    // Half-bit load puts the first strobe at the centre of the start bit.
                    if (!rx_s) begin
                        baud_cnt <= HALF_LOAD;
                        bit_cnt  <= '0;
                        state    <= START;
                    end
                end

                START: begin
                    // A start bit that has gone high by its centre was a glitch.
                    if (strobe_c) begin
                        state <= rx_s ? IDLE : DATA;
                    end
                end

                DATA: begin
                    if (strobe_c) begin
                        shift   <= {rx_s, shift[DATA_W-1:1]};
                        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        if (bit_cnt == LAST_BIT) begin
                            state <= STOP;
                        end
                    end
                end

                STOP: begin
                    // Return to IDLE at the stop-bit centre so a following start edge is not missed.
                    if (strobe_c) begin
                        if (rx_s) begin
                            rx_data <= shift;
                            rdy     <= 1'b1;
                            ovr_err <= (ovr_err | rdy) & ~clr_rdy;
                        end else begin
                            frm_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one instance at a short bit time for the full
// scenario list and one at the production bit time for the latency check.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int unsigned DIV_S = 16;
    localparam int unsigned DIV_B = 2604;
    localparam int L_S = 9 * DIV_S + DIV_S / 2 + 3;
    localparam int L_B = 9 * DIV_B + DIV_B / 2 + 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx_b = 1'b1;
    logic       clr_rdy = 1'b0;
    logic       clr_b = 1'b0;
    logic [7:0] data_s, data_b;
    logic       rdy_s, frm_s, ovr_s;
    logic       rdy_b, frm_b, ovr_b;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int rise_s = -1;
    int rise_b = -1;
    int diff;
    logic rdy_s_q = 1'b0;
    logic rdy_b_q = 1'b0;

    uart_rx #(.BAUD_DIV(DIV_S)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (rx),
        .clr_rdy (clr_rdy),
        .rx_data (data_s),
        .rdy     (rdy_s),
        .frm_err (frm_s),
        .ovr_err (ovr_s)
    );

    uart_rx #(.BAUD_DIV(DIV_B)) dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (rx_b),
        .clr_rdy (clr_b),
        .rx_data (data_b),
        .rdy     (rdy_b),
        .frm_err (frm_b),
        .ovr_err (ovr_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record the cycle of each rdy rising edge.
    always @(negedge clk) begin
        if (rdy_s && !rdy_s_q) rise_s = cyc;
        if (rdy_b && !rdy_b_q) rise_b = cyc;
        rdy_s_q = rdy_s;
        rdy_b_q = rdy_b;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_lat(input string tag, input int d, input int l);
        total++;
        assert (d >= l - 1 && d <= l + 1) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d(+/-1)", tag, d, l);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one 10-bit frame; clr_at>0 pulses clr_rdy so it is high at that edge.
    task automatic send(input logic [7:0] b, input logic stop_bit, input bit big, input int clr_at);
        int div;
        logic [9:0] frame;
        div = big ? int'(DIV_B) : int'(DIV_S);
        frame = {stop_bit, b, 1'b0};
        fall_cyc = cyc;
        for (int k = 0; k < 10 * div; k++) begin
            if (big) rx_b = frame[k / div];
            else     rx   = frame[k / div];
            clr_rdy = (!big && clr_at > 0 && k == clr_at - 1);
            @(posedge clk);
            #1;
        end
        clr_rdy = 1'b0;
        if (big) rx_b = 1'b1;
        else     rx   = 1'b1;
    endtask

    task automatic pulse_clr();
        clr_rdy = 1'b1;
        tick(1);
        clr_rdy = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(3);
        check("rst_data", 32'(data_s), 32'h00);
        check("rst_rdy", 32'(rdy_s), 32'h0);
        check("rst_frm", 32'(frm_s), 32'h0);
        check("rst_ovr", 32'(ovr_s), 32'h0);
        rst_n = 1'b1;
        tick(5);

        // 1: single byte, latency, clr_rdy handshake
        send(CMD_GO, 1'b1, 1'b0, 0);
        diff = rise_s - fall_cyc;
        check_lat("t1_latency", diff, L_S);
        check("t1_data", 32'(data_s), 32'h67);
        check("t1_rdy", 32'(rdy_s), 32'h1);
        pulse_clr();
        check("t1_rdy_clr", 32'(rdy_s), 32'h0);

        // 1 at production bit time
        send(CMD_GO, 1'b1, 1'b1, 0);
        diff = rise_b - fall_cyc;
        check_lat("t1b_latency", diff, L_B);
        check("t1b_data", 32'(data_b), 32'h67);
        check("t1b_rdy", 32'(rdy_b), 32'h1);
        check("t1b_errs", 32'({frm_b, ovr_b}), 32'h0);
        clr_b = 1'b1;
        tick(1);
        clr_b = 1'b0;
        check("t1b_rdy_clr", 32'(rdy_b), 32'h0);

        // 2: back-to-back frames without clear -> overrun
        tick(2 * DIV_S);
        send(CMD_STOP, 1'b1, 1'b0, 0);
        send(8'hA5, 1'b1, 1'b0, 0);
        check("t2_data", 32'(data_s), 32'hA5);
        check("t2_rdy", 32'(rdy_s), 32'h1);
        check("t2_ovr", 32'(ovr_s), 32'h1);
        check("t2_frm", 32'(frm_s), 32'h0);
        pulse_clr();
        check("t2_flags_clr", 32'({rdy_s, frm_s, ovr_s}), 32'h0);

        // 3: short glitch is a false start
        tick(2 * DIV_S);
        rx = 1'b0;
        tick(DIV_S / 4);
        rx = 1'b1;
        tick(3 * DIV_S);
        check("t3_glitch_rdy", 32'(rdy_s), 32'h0);
        check("t3_glitch_frm", 32'(frm_s), 32'h0);
        send(CMD_GO, 1'b1, 1'b0, 0);
        check("t3_data", 32'(data_s), 32'h67);
        check("t3_rdy", 32'(rdy_s), 32'h1);
        check("t3_errs", 32'({frm_s, ovr_s}), 32'h0);
        pulse_clr();

        // 4: framing error keeps data, then clean frame
        tick(2 * DIV_S);
        send(8'h55, 1'b0, 1'b0, 0);
        check("t4_frm", 32'(frm_s), 32'h1);
        check("t4_rdy", 32'(rdy_s), 32'h0);
        check("t4_data_kept", 32'(data_s), 32'h67);
        tick(3 * DIV_S);
        check("t4_no_spurious", 32'(rdy_s), 32'h0);
        send(8'h3C, 1'b1, 1'b0, 0);
        check("t4_data", 32'(data_s), 32'h3C);
        check("t4_rdy2", 32'(rdy_s), 32'h1);

        // 5: reset mid-frame after four data bits of 0xFF
        tick(2 * DIV_S);
        check("t5_pre_frm", 32'(frm_s), 32'h1);
        rx = 1'b0;
        tick(DIV_S);
        rx = 1'b1;
        tick(4 * DIV_S);
        rst_n = 1'b0;
        #1;
        check("t5_rst_data", 32'(data_s), 32'h00);
        check("t5_rst_flags", 32'({rdy_s, frm_s, ovr_s}), 32'h0);
        tick(5);
        rst_n = 1'b1;
        tick(2 * DIV_S);
        send(8'h81, 1'b1, 1'b0, 0);
        check("t5_data", 32'(data_s), 32'h81);
        check("t5_rdy", 32'(rdy_s), 32'h1);
        check("t5_errs", 32'({frm_s, ovr_s}), 32'h0);

        // 6: clr_rdy coincident with completion strobe while rdy=1
        tick(2 * DIV_S);
        send(8'h12, 1'b1, 1'b0, L_S);
        check("t6_rdy", 32'(rdy_s), 32'h1);
        check("t6_ovr", 32'(ovr_s), 32'h0);
        check("t6_data", 32'(data_s), 32'h12);
        check("t6_frm", 32'(frm_s), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
